// File: rtl/fft8_stage_controller_if.sv
// ---------------------------------------------------------------------------
// fft8_stage_controller_if
// Request and writeback bundle between the FFT stage controller and the
// fixed-latency fp16 butterfly unit / working memory.
//
// Handshake: a request (addr_a, addr_b, tw_sel) transfers on a rising clk
// edge where bf_valid and bf_ready are both high. Once bf_valid is raised,
// the request fields hold steady until that transfer. wb_valid carries no
// ready: it is a one-cycle strobe and the memory must take wb_addr_a/b then.
//
// Signals:
//   bf_valid  - request valid (controller -> unit)
//   bf_ready  - unit accepts the request (unit -> controller)
//   addr_a/b  - top/bottom operand addresses
//   tw_sel    - twiddle index W8^tw_sel
//   wb_valid  - writeback strobe for one butterfly result pair
//   wb_addr_a/b - writeback addresses for top/bottom results
// ---------------------------------------------------------------------------
interface fft8_stage_controller_if;
   logic       bf_valid;
   logic       bf_ready;
   logic [2:0] addr_a;
   logic [2:0] addr_b;
   logic [1:0] tw_sel;
   logic       wb_valid;
   logic [2:0] wb_addr_a;
   logic [2:0] wb_addr_b;

   modport master (
      output bf_valid, addr_a, addr_b, tw_sel, wb_valid, wb_addr_a, wb_addr_b,
      input  bf_ready
   );

   modport slave (
      input  bf_valid, addr_a, addr_b, tw_sel, wb_valid, wb_addr_a, wb_addr_b,
      output bf_ready
   );
endinterface

// File: rtl/fft8_stage_controller.sv
// ---------------------------------------------------------------------------
// fft8_stage_controller
// Sequences one 8-point radix-2 DIT FFT/IFFT over an in-place memory holding
// bit-reversed input: 3 stages x 4 butterflies, issued to a butterfly unit of
// fixed latency BFLY_LATENCY. A stage begins only after every butterfly of
// the previous stage has been written back.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin a transform (honoured only in IDLE)
//   mode_in     - 0 = FFT, 1 = IFFT, captured with start
//   abort       - synchronous cancel back to IDLE, no done pulse
//   busy        - high in every state except IDLE
//   done        - one-cycle completion pulse
//   fftorifft   - latched mode for the twiddle ROM
//   stage       - current stage 0..2
//   bf          - butterfly request / writeback bundle (master side)
// ---------------------------------------------------------------------------
module fft8_stage_controller #(
   parameter int BFLY_LATENCY = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           mode_in,
   input  logic                           abort,
   output logic                           busy,
   output logic                           done,
   output logic                           fftorifft,
   output logic [1:0]                     stage,
   fft8_stage_controller_if.master        bf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] k_q, k_d;
   logic [1:0] stage_q, stage_d;
   logic       mode_q, mode_d;
   logic [2:0] cnt_q, cnt_d;

   // Shadow of the butterfly pipeline: which slots hold a live butterfly
   // and where its results go.
   logic       vld_q [BFLY_LATENCY];
   logic       vld_d [BFLY_LATENCY];
   logic [2:0] pa_q  [BFLY_LATENCY];
   logic [2:0] pa_d  [BFLY_LATENCY];
   logic [2:0] pb_q  [BFLY_LATENCY];
   logic [2:0] pb_d  [BFLY_LATENCY];

   logic       accept;
   logic       wb_fire;
   logic [2:0] a_raw, b_raw;
   logic [1:0] tw_raw;

   // Operand addressing from (stage, k): span = 1<<stage.
   always_comb begin
      a_raw  = 3'd0;
      b_raw  = 3'd0;
      tw_raw = 2'd0;
      unique case (stage_q)
         2'd0: begin
            a_raw = {k_q, 1'b0};
            b_raw = {k_q, 1'b1};
         end
         2'd1: begin
            a_raw  = {k_q[1], 1'b0, k_q[0]};
            b_raw  = {k_q[1], 1'b1, k_q[0]};
            tw_raw = {k_q[0], 1'b0};
         end
         2'd2: begin
            a_raw  = {1'b0, k_q};
            b_raw  = {1'b1, k_q};
            tw_raw = k_q;
         end
         default: begin
            a_raw  = 3'd0;
            b_raw  = 3'd0;
            tw_raw = 2'd0;
         end
      endcase
   end

   assign bf.bf_valid  = (state_q == ISSUE);
   // Addresses are forced to zero outside ISSUE so idle outputs read as 0.
   assign bf.addr_a    = bf.bf_valid ? a_raw  : 3'd0;
   assign bf.addr_b    = bf.bf_valid ? b_raw  : 3'd0;
   assign bf.tw_sel    = bf.bf_valid ? tw_raw : 2'd0;
   assign bf.wb_valid  = vld_q[BFLY_LATENCY-1];
   assign bf.wb_addr_a = pa_q[BFLY_LATENCY-1];
   assign bf.wb_addr_b = pb_q[BFLY_LATENCY-1];

   assign accept  = bf.bf_valid & bf.bf_ready;
   assign wb_fire = vld_q[BFLY_LATENCY-1];

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign fftorifft = mode_q;
   assign stage     = stage_q;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      stage_d = stage_q;
      mode_d  = mode_q;

      unique case ({accept, wb_fire})
         2'b10:   cnt_d = cnt_q + 3'd1;
         2'b01:   cnt_d = cnt_q - 3'd1;
         default: cnt_d = cnt_q;
      endcase

      vld_d[0] = accept;
      pa_d[0]  = a_raw;
      pb_d[0]  = b_raw;
      for (int i = 1; i < BFLY_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         pa_d[i]  = pa_q[i-1];
         pb_d[i]  = pb_q[i-1];
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               mode_d  = mode_in;
               stage_d = 2'd0;
               k_d     = 2'd0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (accept) begin
               k_d = k_q + 2'd1;
               if (k_q == 2'd3) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Registered count, so the last writeback must have retired.
            if (cnt_q == 3'd0) begin
               if (stage_q == 2'd2) begin
                  state_d = DONE;
               end else begin
                  stage_d = stage_q + 2'd1;
                  k_d     = 2'd0;
                  state_d = ISSUE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort overrides start, accept and pending writebacks; the latched
      // mode is left untouched.
      if (abort) begin
         state_d = IDLE;
         k_d     = 2'd0;
         stage_d = 2'd0;
         mode_d  = mode_q;
         cnt_d   = 3'd0;
         for (int i = 0; i < BFLY_LATENCY; i++) begin
            vld_d[i] = 1'b0;
            pa_d[i]  = 3'd0;
            pb_d[i]  = 3'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= 2'd0;
         stage_q <= 2'd0;
         mode_q  <= 1'b0;
         cnt_q   <= 3'd0;
         for (int i = 0; i < BFLY_LATENCY; i++) begin
            vld_q[i] <= 1'b0;
            pa_q[i]  <= 3'd0;
            pb_q[i]  <= 3'd0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         stage_q <= stage_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < BFLY_LATENCY; i++) begin
            vld_q[i] <= vld_d[i];
            pa_q[i]  <= pa_d[i];
            pb_q[i]  <= pb_d[i];
         end
      end
   end

endmodule

// File: tb/tb_fft8_stage_controller.sv
// ---------------------------------------------------------------------------
// tb_fft8_stage_controller
// Directed bench for fft8_stage_controller with BFLY_LATENCY = 4. Outputs
// are sampled and inputs driven on the falling clock edge; "cycle n" is the
// clock period in which start was driven being cycle 0.
// ---------------------------------------------------------------------------
module tb_fft8_stage_controller;
   localparam int LAT = 4;

   logic clk;
   logic rst_n;
   logic start;
   logic mode_in;
   logic abort;
   logic busy;
   logic done;
   logic fftorifft;
   logic [1:0] stage;

   fft8_stage_controller_if bif ();

   fft8_stage_controller #(.BFLY_LATENCY(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode_in   (mode_in),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .fftorifft (fftorifft),
      .stage     (stage),
      .bf        (bif)
   );

   int n_cmp = 0;
   int n_err = 0;

   // {addr_a, addr_b, tw_sel} in issue order, hand-derived.
   logic [7:0] req_tbl [12];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one full transform starting from IDLE at a falling edge.
   // stall: bf_ready only on odd cycles. exp_done < 0 skips the cycle check.
   // wiggle: flip mode_in and pulse start while busy.
   task automatic run_xform(input logic mode, input bit stall, input int exp_done,
                            input bit wiggle);
      logic [5:0] exp_q[$];
      int         due_q[$];
      int         cyc, idx, wbn, due;
      bit         fin, prev_stall;
      logic [7:0] prev_req, cur_req;
      logic [5:0] exp_ab;
      exp_q.delete();
      due_q.delete();
      idx = 0; wbn = 0; fin = 0; prev_stall = 0; prev_req = '0;
      start = 1'b1; mode_in = mode; bif.bf_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!fin && cyc < 300) begin
         if (wiggle && cyc == 5) mode_in = ~mode;
         if (wiggle && cyc == 8) begin start = 1'b1; mode_in = ~mode; end
         if (wiggle && cyc == 9) start = 1'b0;
         bif.bf_ready = stall ? cyc[0] : 1'b1;
         chk("fftorifft", fftorifft, mode);
         chk("busy", busy, 1);
         cur_req = {bif.addr_a, bif.addr_b, bif.tw_sel};
         if (bif.bf_valid) begin
            chk("req_count", idx < 12, 1);
            if (idx < 12) begin
               chk($sformatf("req%0d", idx), cur_req, req_tbl[idx]);
               chk("stage", stage, idx / 4);
               chk("stage_order", wbn >= 4 * (idx / 4), 1);
            end
            if (prev_stall) chk("stall_hold", cur_req, prev_req);
         end
         if (bif.wb_valid) begin
            chk("wb_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               exp_ab = exp_q.pop_front();
               due    = due_q.pop_front();
               chk("wb_addr", {bif.wb_addr_a, bif.wb_addr_b}, exp_ab);
               chk("wb_cycle", cyc, due);
            end
            wbn++;
         end
         if (done) begin
            chk("done_reqs", idx, 12);
            chk("done_wbs", wbn, 12);
            if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
            fin = 1;
         end
         prev_stall = bif.bf_valid && !bif.bf_ready;
         prev_req   = cur_req;
         if (bif.bf_valid && bif.bf_ready) begin
            exp_q.push_back({bif.addr_a, bif.addr_b});
            due_q.push_back(cyc + LAT);
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("finished", fin, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_wb", bif.wb_valid, 0);
      chk("idle_mode", fftorifft, mode);
      bif.bf_ready = 1'b1;
   endtask

   initial begin
      req_tbl = '{
         {3'd0, 3'd1, 2'd0}, {3'd2, 3'd3, 2'd0}, {3'd4, 3'd5, 2'd0}, {3'd6, 3'd7, 2'd0},
         {3'd0, 3'd2, 2'd0}, {3'd1, 3'd3, 2'd2}, {3'd4, 3'd6, 2'd0}, {3'd5, 3'd7, 2'd2},
         {3'd0, 3'd4, 2'd0}, {3'd1, 3'd5, 2'd1}, {3'd2, 3'd6, 2'd2}, {3'd3, 3'd7, 2'd3}
      };
      rst_n = 1'b0; start = 1'b0; mode_in = 1'b0; abort = 1'b0; bif.bf_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mode", fftorifft, 0);
      chk("rst_stage", stage, 0);
      chk("rst_bf_valid", bif.bf_valid, 0);
      chk("rst_addr", {bif.addr_a, bif.addr_b, bif.tw_sel}, 0);
      chk("rst_wb", {bif.wb_valid, bif.wb_addr_a, bif.wb_addr_b}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Plain FFT, ready tied high
      run_xform(1'b0, 1'b0, 28, 1'b0);

      // IFFT with mode_in flipped and start pulsed while busy
      run_xform(1'b1, 1'b0, 28, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("mode_hold_idle", fftorifft, 1);
      end

      // Start together with abort in IDLE is ignored
      start = 1'b1; abort = 1'b1; mode_in = 1'b0;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", busy, 0);
      chk("sa_mode", fftorifft, 1);
      repeat (4) begin
         @(negedge clk);
         chk("sa_busy_hold", busy, 0);
         chk("sa_no_done", done, 0);
      end

      // Stalled butterfly unit
      run_xform(1'b0, 1'b1, -1, 1'b0);

      // Abort in stage 1 DRAIN with two in flight (cycle 16)
      start = 1'b1; mode_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(negedge clk);
      chk("ab_stage", stage, 1);
      chk("ab_drain", bif.bf_valid, 0);
      chk("ab_wb_before", bif.wb_valid, 1);
      chk("ab_busy_before", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_busy", busy, 0);
      chk("ab_bf_valid", bif.bf_valid, 0);
      chk("ab_wb", bif.wb_valid, 0);
      chk("ab_stage0", stage, 0);
      repeat (12) begin
         @(negedge clk);
         chk("ab_no_wb", bif.wb_valid, 0);
         chk("ab_no_done", done, 0);
         chk("ab_idle", busy, 0);
      end
      run_xform(1'b1, 1'b0, 28, 1'b0);

      // Asynchronous reset during stage 2 ISSUE (cycle 20)
      start = 1'b1; mode_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      chk("rs_pre_valid", bif.bf_valid, 1);
      chk("rs_pre_stage", stage, 2);
      rst_n = 1'b0;
      #1;
      chk("rs_busy", busy, 0);
      chk("rs_done", done, 0);
      chk("rs_mode", fftorifft, 0);
      chk("rs_stage", stage, 0);
      chk("rs_req", {bif.bf_valid, bif.addr_a, bif.addr_b, bif.tw_sel}, 0);
      chk("rs_wb", {bif.wb_valid, bif.wb_addr_a, bif.wb_addr_b}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rs_idle", busy, 0);
      run_xform(1'b0, 1'b0, 28, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fft8_stage_controller.md
Name: fft8_stage_controller

Overview:
Sequences one 8-point radix-2 DIT FFT/IFFT over an in-place working memory that holds bit-reversed input. Issues 12 butterfly operations (3 stages × 4) to a fixed-latency fp16 butterfly unit, each with operand addresses and a twiddle index. Drives the FFT/IFFT select into the twiddle ROM and tracks in-flight butterflies so a stage starts only after the previous stage is fully written back.

Parameters:
BFLY_LATENCY, 4, cycles from butterfly accept to result writeback; legal range 1..7.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin transform; sampled only in IDLE
mode_in  in  1  0 = FFT, 1 = IFFT; captured when start is accepted
abort  in  1  synchronous cancel; returns to IDLE with no done pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the transform completes
fftorifft  out  1  latched mode, drives the twiddle ROM select
stage  out  2  current stage, 0..2
bf_valid  out  1  butterfly request valid
bf_ready  in  1  butterfly unit accepts the request
addr_a  out  3  top operand address
addr_b  out  3  bottom operand address
tw_sel  out  2  twiddle index W8^tw_sel
wb_valid  out  1  writeback strobe for the results of one butterfly
wb_addr_a  out  3  writeback address for the top result
wb_addr_b  out  3  writeback address for the bottom result

Behaviour:
- Reset: all outputs 0, FSM in IDLE, k=0, stage=0, in-flight count=0, shadow pipeline cleared. Reset may assert at any time, including mid-transform.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start=1: latch fftorifft<=mode_in, set stage=0 and k=0, go to ISSUE. A start in any other state is ignored.
- ISSUE:
  - bf_valid=1; addr_a, addr_b and tw_sel are combinational from (stage, k).
  - An accept is bf_valid&bf_ready. Each accept increments k.
  - The accept with k=3 moves the FSM to DRAIN.
  - While bf_ready=0, all request outputs stay stable.
- Addressing, with span = 1<<stage:
  - addr_a = (k>>stage)*2*span + (k & (span-1)).
  - addr_b = addr_a + span.
  - tw_sel = (k & (span-1)) * (4>>stage).
  - Stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
- Shadow pipeline:
  - BFLY_LATENCY-deep shift register of {valid, addr_a, addr_b}.
  - Loaded on accept; shifts every cycle.
  - The butterfly unit never stalls after accept.
  - wb_valid, wb_addr_a and wb_addr_b are the registered tail of the shift register. For an accept in cycle t, wb_valid is high in cycle t+BFLY_LATENCY.
- In-flight count (3 bits):
  - +1 on accept, −1 on wb_valid.
  - Both in the same cycle leaves it unchanged.
- DRAIN, when the registered in-flight count = 0:
  - stage<2: stage+1, k=0, go to ISSUE.
  - stage=2: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 in DONE.
- fftorifft holds its latched value until the next accepted start, including through IDLE.
- Timing with bf_ready tied 1:
  - Each stage occupies BFLY_LATENCY+5 cycles from its first ISSUE cycle to the next stage's first ISSUE cycle.
  - With start sampled in cycle 0, done is high in cycle 3*BFLY_LATENCY+16.
- Abort, in any non-IDLE state: on the next edge go to IDLE.
  - Clear bf_valid, the shadow pipeline, the in-flight count, k and stage.
  - Suppress any pending wb_valid; no done pulse.
  - Abort has priority over the same-cycle accept and over start.
- Simultaneous start and abort in IDLE: abort wins and start is ignored.

Test Plan:
1. L=4, bf_ready=1, start with mode_in=0 → 12 requests in the address/tw_sel order listed above; each wb_valid appears exactly 4 cycles after its accept with matching addresses; done pulses in cycle 28; fftorifft=0 throughout.
2. start with mode_in=1, then change mode_in to 0 mid-run → fftorifft stays 1 until the next start; sequence identical to scenario 1.
3. Random bf_ready stalls (e.g. low on every other cycle) → requests are held stable while stalled; no stage-(s+1) request is issued before the last stage-s wb_valid; exactly 12 wb_valid strobes, then one done.
4. Abort during stage 1 DRAIN with 2 in flight → next cycle busy=0, bf_valid=0, no further wb_valid, no done; a following start runs a clean full transform.
5. Assert rst_n=0 during stage 2 ISSUE → all outputs go to 0 immediately (asynchronously); after release the FSM is IDLE and start behaves as in scenario 1.
6. Pulse start while busy, and start+abort together in IDLE → both ignored: no restart, no extra done, no change to fftorifft.
